// File: rtl/ahb_lite_sram_slave_pkg.sv
// AHB-Lite encodings, slave FSM state codes and the byte-lane helper shared by the SRAM slave.
// Pure definitions: no latency, no backpressure.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << lo;
            HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lane_mask = 4'b1111;
            default:    lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master/mux side and the SRAM slave.
// Wires only: no latency; HREADYOUT/HREADY carry the wait-state backpressure.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_mem.sv
// MEM_DEPTH x 32 storage, byte write enables on the clock edge, combinational read.
// Write lands at the edge, read is zero-latency; no backpressure. Contents are never reset.
module ahb_lite_sram_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: WAIT_STATES data-phase waits per OKAY transfer, two-cycle ERROR for bad ones.
// Pipelines back-to-back transfers out of S_DONE; stalls the bus with HREADYOUT=0 in S_WAIT/S_ERR1.
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]    state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] d_idx;
    logic [1:0]    d_lo;
    logic [2:0]    d_size;
    logic          d_write;
    logic          trans_active, accept, can_start, flag_err;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;
    logic          unused_ok;

    always_comb begin
        trans_active = 1'b0;
        case (bus.HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
        endcase
    end

    assign can_start = (state != S_WAIT) && (state != S_ERR1);
    assign accept    = bus.HSEL && bus.HREADY && trans_active;
    assign flag_err  = (bus.HSIZE > HSIZE_WORD)
                    || ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0])
                    || ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00))
                    || (bus.HADDR[31:2] >= DEPTH_W);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (flag_err) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end else begin
                    state_nxt = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            d_idx   <= '0;
            d_lo    <= 2'b00;
            d_size  <= 3'd0;
            d_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (can_start && accept) begin
                d_idx   <= bus.HADDR[AW+1:2];
                d_lo    <= bus.HADDR[1:0];
                d_size  <= bus.HSIZE;
                d_write <= bus.HWRITE;
            end
        end
    end

    // Flagged transfers never reach S_DONE, so they can never write.
    assign mem_we = ((state == S_DONE) && d_write) ? lane_mask(d_size, d_lo) : 4'b0000;

    ahb_lite_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .clk   (HCLK),
        .addr  (d_idx),
        .we    (mem_we),
        .wdata (bus.HWDATA),
        .rdata (mem_rdata)
    );

    assign bus.HRDATA    = (((state == S_WAIT) || (state == S_DONE)) && !d_write) ? mem_rdata : 32'd0;
    assign bus.HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    assign bus.HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    assign unused_ok = ^bus.HBURST;
endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter: MEM_DEPTH, 64, number of 32-bit words in storage (power of two).
REQ-002 SHALL have parameter: WAIT_STATES, 1, data-phase wait cycles for OKAY transfers (0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: HCLK  in  1  clock, all state on rising edge.
REQ-005 SHALL have port: HRESET  in  1  asynchronous active-high reset.
REQ-006 SHALL have port: HSEL  in  1  slave select from the address decoder.
REQ-007 SHALL have port: HADDR  in  32  transfer address.
REQ-008 SHALL have port: HWRITE  in  1  1=write, 0=read.
REQ-009 SHALL have port: HSIZE  in  3  0=byte, 1=halfword, 2=word.
REQ-010 SHALL have port: HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 SHALL have port: HBURST  in  3  burst type, accepted and ignored.
REQ-012 SHALL have port: HWDATA  in  32  write data, valid in the data phase.
REQ-013 SHALL have port: HREADY  in  1  bus ready from the response multiplexer.
REQ-014 SHALL have port: HRDATA  out  32  read data.
REQ-015 SHALL have port: HREADYOUT  out  1  slave ready; 0 inserts a wait state.
REQ-016 SHALL have port: HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-017 SHALL sample an address phase only on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; the sample captures word index HADDR[log2(MEM_DEPTH)+1:2], HADDR[1:0], HSIZE and HWRITE.
REQ-018 SHALL give IDLE, BUSY and unselected cycles a zero-wait OKAY response (HREADYOUT=1, HRESP=0) with no storage access.
REQ-019 SHALL flag a sampled transfer as an error when any of these holds: HSIZE>2; halfword with HADDR[0]=1; word with HADDR[1:0]!=0; HADDR[31:2] >= MEM_DEPTH.
REQ-020 SHALL implement FSM states S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2.
REQ-021 On S_IDLE/S_DONE/S_ERR2 plus a sampled transfer, SHALL go to S_ERR1 if flagged; else to S_WAIT when WAIT_STATES>0 (counter loaded with WAIT_STATES-1), or to S_DONE when WAIT_STATES=0.
REQ-022 On S_IDLE/S_DONE/S_ERR2 with no sampled transfer, SHALL go to S_IDLE.
REQ-023 In S_WAIT, SHALL drive HREADYOUT=0, HRESP=0, and decrement the counter; at counter 0 it SHALL go to S_DONE.
REQ-024 In S_DONE, SHALL drive HREADYOUT=1, HRESP=0; a write SHALL update only the byte lanes selected by HSIZE/HADDR[1:0] from HWDATA at the closing edge.
REQ-025 S_ERR1 SHALL drive HREADYOUT=0, HRESP=1; it SHALL always go to S_ERR2.
REQ-026 S_ERR2 SHALL drive HREADYOUT=1, HRESP=1.
REQ-027 Flagged transfers SHALL never modify storage.
REQ-028 In the data phase of a read (S_WAIT/S_DONE), HRDATA SHALL be the full addressed word, combinationally from storage; otherwise HRDATA SHALL be 0.
REQ-029 Back-to-back transfers SHALL pipeline: an address phase sampled in S_DONE starts the next data phase with no idle cycle.
REQ-030 A read immediately following a write to the same word SHALL return the newly written data.

Reset
REQ-031 Asserting HRESET SHALL immediately force S_IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, and discard any captured transfer, including mid-wait or mid-error.
REQ-032 Storage contents SHALL NOT be reset.

Structure
REQ-033 Package ahb_lite_pkg SHALL hold the HTRANS, HSIZE and HRESP encodings and the FSM state encoding.
REQ-034 Storage SHALL be the sub-module ahb_lite_sram_mem: MEM_DEPTH x 32 bits, 4-bit byte-write enable, asynchronous read port.

Verification
REQ-035 Bench SHALL cover: write word 0xDEADBEEF to 0x10, then read 0x10 -> one wait cycle each (WAIT_STATES=1), HRESP=0, HRDATA=0xDEADBEEF.
REQ-036 Bench SHALL cover: byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
REQ-037 Bench SHALL cover: halfword read at 0x01 -> HREADYOUT=0,HRESP=1, then HREADYOUT=1,HRESP=1; storage unchanged.
REQ-038 Bench SHALL cover: word write to 0x100 (index 64, MEM_DEPTH=64) -> two-cycle ERROR, no write.
REQ-039 Bench SHALL cover, with WAIT_STATES=0: NONSEQ then SEQ writes at 0x0/0x4, then read 0x4 -> HREADYOUT constantly 1 and correct data.
REQ-040 Bench SHALL cover: HRESET pulsed during S_WAIT -> HREADYOUT=1, HRESP=0 at once; the next transfer completes normally.
